vector_mem_sequencer: RTL

// Parametrised vector load/store sequencer between the EX/MEM stage and the element-wide data RAM.

---
 rtl/vector_mem_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: serialises a LANES-element access into per-element RAM cycles.
// Optional feature macro: VSEQ_STRIDE_EN (signed per-request stride; default build uses stride 1).
module vector_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshake: a request is taken on a rising edge where req_valid_i && req_ready_o;
  // req_ready_o is high only while idle, and the requester holds the request until taken.
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_base_i,
  input  logic [ADDR_W-1:0]       req_stride_i,
  input  logic [4:0]              req_rd_i,
  input  logic [LANES*ELEM_W-1:0] req_wdata_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [ELEM_W-1:0]       mem_wdata_o,
  output logic                    mem_wren_o,
  input  logic [ELEM_W-1:0]       mem_rdata_i,
  output logic                    resp_valid_o,
  output logic                    resp_write_o,
  output logic [4:0]              resp_rd_o,
  output logic [LANES*ELEM_W-1:0] resp_rdata_o,
  output logic [1:0]              dbg_state_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      write_q;
  logic [4:0]                rd_q;
  logic [LANES*ELEM_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [ADDR_W-1:0]         stride_w;
  logic [LW-1:0]             lane_q;
  logic                      pipe_vld_q  [RD_LAT];
  logic [LW-1:0]             pipe_lane_q [RD_LAT];
  logic [LANES*ELEM_W-1:0]   gather_q, gather_d;
  logic [LANES*ELEM_W-1:0]   resp_rdata_q;
  logic [LANES*ELEM_W-1:0]   wdata_sh;
  logic                      accept;
  logic                      tap_vld;
  logic [LW-1:0]             tap_lane;
  logic                      cap_last;

`ifdef VSEQ_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= '0;
    end else if (accept) begin
      stride_q <= req_stride_i;
    end
  end

  assign stride_w = stride_q;
`else
  logic unused_stride;

  assign unused_stride = ^req_stride_i;
  assign stride_w      = ADDR_W'(1);
`endif

  assign accept   = req_valid_i && (state_q == S_IDLE);
  assign tap_vld  = pipe_vld_q[RD_LAT-1];
  assign tap_lane = pipe_lane_q[RD_LAT-1];
  assign cap_last = tap_vld && (tap_lane == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The last load lane arrives RD_LAT cycles after issue, so DRAIN ends on its capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (lane_q == LAST_LANE) state_d = write_q ? S_DONE : S_DRAIN;
      S_DRAIN: if (cap_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gather_d = gather_q;
    if (tap_vld) begin
      for (int k = 0; k < LANES; k++) begin
        if (tap_lane == LW'(k)) gather_d[k*ELEM_W +: ELEM_W] = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q      <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      lane_q       <= '0;
      gather_q     <= '0;
      resp_rdata_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_lane_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        write_q <= req_write_i;
        rd_q    <= req_rd_i;
        wdata_q <= req_wdata_i;
        addr_q  <= req_base_i;
        lane_q  <= '0;
      end else if (state_q == S_ISSUE) begin
        addr_q <= addr_q + stride_w;
        lane_q <= lane_q + LW'(1);
      end
      // Lane tag travels alongside the RAM read so each word lands in its own slot.
      pipe_vld_q[0]  <= (state_q == S_ISSUE) && !write_q;
      pipe_lane_q[0] <= lane_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_lane_q[k] <= pipe_lane_q[k-1];
      end
      gather_q <= gather_d;
      if (cap_last) resp_rdata_q <= gather_d;
    end
  end

  always_comb begin
    wdata_sh     = wdata_q >> (ELEM_W * lane_q);
    req_ready_o  = (state_q == S_IDLE);
    mem_wren_o   = (state_q == S_ISSUE) && write_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = mem_wren_o ? wdata_sh[ELEM_W-1:0] : '0;
    resp_valid_o = (state_q == S_DONE);
    resp_write_o = write_q;
    resp_rd_o    = rd_q;
    resp_rdata_o = resp_rdata_q;
    dbg_state_o  = state_q;
  end

endmodule
